spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
SPI mode-0 slave that turns serial frames from the test host into parallel register reads and writes for a TinyQV byte peripheral. It sits directly upstream of the peripheral.
- Drives: address, write data and a one-cycle write strobe.
- Returns: the peripheral's combinational read data on MISO.
- All SPI inputs arrive already 2-stage synchronized to clk; the block works purely in the clk domain using edge detection.

Parameters:
ADDR_W, 4, width of reg_addr; frame address field is 7 bits, only low ADDR_W bits used, upper bits ignored.

Ports:
clk  input  1  system clock
rstb  input  1  asynchronous active-low reset
ena  input  1  frame accept enable; sampled at cs_n falling edge
spi_cs_n  input  1  synchronized chip select, active low
spi_clk  input  1  synchronized SPI clock, idle low
spi_mosi  input  1  synchronized serial data in, MSB first
spi_miso  output  1  serial data out
reg_addr  output  ADDR_W  register address to peripheral
reg_data_i  input  8  read data from peripheral (combinational from reg_addr)
reg_data_o  output  8  write data to peripheral
reg_data_o_dv  output  1  one-cycle write strobe

Behaviour:
- Reset (async on rstb low): all outputs 0, state IDLE, bit counter 0, shift registers 0.
- Edge detect: registered copies of spi_clk and spi_cs_n.
  - rise = clk 0->1; fall = clk 1->0; start = cs_n 1->0.
  - Host guarantees SPI half-period >= 4 clk cycles.
- Frame format, 16 bits, MSB first:
  - bit15 = RW (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
  - Bits are sampled on rise.
- State machines:
  - IDLE: on start with ena=1 -> CMD, counter 0. With ena=0, stay IDLE and ignore the frame; miso stays 0.
  - CMD: shift mosi on each rise. After the 8th rise:
    - the following cycle updates reg_addr;
    - the cycle after that captures reg_data_i into tx_shift;
    - -> DATA.
  - DATA:
    - Read: the 8th fall drives miso = tx_shift[7]; each subsequent fall shifts left.
    - Write: collects 8 mosi bits. On the 16th rise, reg_data_o is loaded and reg_data_o_dv pulses high for exactly 1 cycle, 1 cycle after the rise is detected.
    - -> DONE.
  - DONE: ignore further clocks until cs_n high (see optional feature).
- cs_n high in any state:
  - state -> IDLE next cycle; miso -> 0.
  - No strobe for an incomplete frame (abort before 16th rise); reg_addr holds its last value.
- Reads never pulse reg_data_o_dv; reg_data_o holds its last written value.
- spi_miso is 0 whenever cs_n is high, in CMD, and in write frames.
- Simultaneous start and stale rise in the same cycle: start wins and the counter resets.
- Reset mid-frame: immediate return to reset values. The frame is lost, and the next frame needs a fresh cs_n falling edge.

Optional Feature:
Macro SPI_REG_BRIDGE_BURST_EN.
- Defined: DONE is replaced by burst continuation. Every further 8 rises after bit 16:
  - reg_addr increments by 1, modulo 2^ADDR_W, wrapping 15 -> 0 for ADDR_W=4.
  - Write: each complete extra byte pulses reg_data_o_dv with the new address.
  - Read: reg_data_i at the new address is captured 2 cycles after the increment, and shifted out starting on the next byte's first fall.
  - A partial trailing byte is discarded.
- Undefined: bits beyond 16 are ignored, with no address change, no strobe, and miso 0.

Test Plan:
1. Write frame 0x85A5 (RW=1, addr 5, data 0xA5) -> reg_addr=5, reg_data_o=0xA5, reg_data_o_dv high exactly 1 cycle, once.
2. Read frame 0x0300 with peripheral returning 0x3C at addr 3 -> reg_addr=3, MISO bits 0,0,1,1,1,1,0,0 sampled on rises 9-16, no dv pulse.
3. Write 0x8277 with cs_n raised after 12 bits, then full write 0x8211 -> no strobe for the first; one strobe with data 0x11 at addr 2.
4. ena=0 at cs_n fall, write 0x8FFF -> no strobe, reg_addr unchanged, miso 0 throughout.
5. rstb pulsed low mid-write after 10 bits, then write 0x8142 -> all outputs 0 during reset; exactly one strobe, addr 1, data 0x42.
6. BURST_EN: write 0x8F01 followed by bytes 0x02, 0x03 -> strobes at addr 15/0x01, addr 0/0x02, addr 1/0x03. Without the macro, only the first strobe occurs.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit host frames into register reads/writes for a byte peripheral.
// Optional burst continuation is enabled by defining SPI_REG_BRIDGE_BURST_EN.
//
// state   | meaning
// S_IDLE  | waiting for cs_n falling edge with ena high
// S_CMD   | shifting in RW + 7-bit address
// S_ADDR  | drive reg_addr from the command byte
// S_CAPT  | capture peripheral read data into tx shift register
// S_DATA  | shifting data byte (write in on rise, read out on fall)
// S_INC   | burst only: advance reg_addr before the next byte
// S_DONE  | frame complete, ignore clocks until cs_n rises
module spi_reg_bridge #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [7:0]        reg_data_i,
  output logic [7:0]        reg_data_o,
  output logic              reg_data_o_dv
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_CAPT, S_DATA, S_INC, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              sclk_q, csn_q;
  logic              rise, fall, start, byte_done;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        rx_q, tx_q;
  logic              is_wr_q;
  logic              miso_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              dv_q;

  assign rise      = spi_clk & ~sclk_q;
  assign fall      = ~spi_clk & sclk_q;
  assign start     = csn_q & ~spi_cs_n;
  assign byte_done = rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (spi_cs_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start && ena) state_d = S_CMD;
        S_CMD:  if (byte_done) state_d = S_ADDR;
        S_ADDR: state_d = S_CAPT;
        S_CAPT: state_d = S_DATA;
`ifdef SPI_REG_BRIDGE_BURST_EN
        S_DATA: if (byte_done) state_d = S_INC;
`else
        S_DATA: if (byte_done) state_d = S_DONE;
`endif
        S_INC:  state_d = S_CAPT;
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_q    <= 1'b0;
      csn_q     <= 1'b0;  // low so a frame already in progress at reset release is never seen as a start
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      is_wr_q   <= 1'b0;
      miso_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dv_q      <= 1'b0;
    end else begin
      sclk_q <= spi_clk;
      csn_q  <= spi_cs_n;
      dv_q   <= 1'b0;
      if (spi_cs_n) begin
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
          end
          S_CMD: begin
            if (rise) begin
              rx_q      <= {rx_q[6:0], spi_mosi};
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          S_ADDR: begin
            addr_q  <= rx_q[ADDR_W-1:0];
            is_wr_q <= rx_q[7];
          end
          S_CAPT: tx_q <= reg_data_i;
          S_DATA: begin
            if (rise) begin
              rx_q      <= {rx_q[6:0], spi_mosi};
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done && is_wr_q) begin
              wdata_q <= {rx_q[6:0], spi_mosi};
              dv_q    <= 1'b1;
            end
`ifndef SPI_REG_BRIDGE_BURST_EN
            if (byte_done) miso_q <= 1'b0;
`endif
            if (fall && !is_wr_q) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
          // Increment lands after the strobe cycle so the strobe carries the old address.
          S_INC:  addr_q <= addr_q + 1'b1;
          S_DONE: miso_q <= 1'b0;
          default: miso_q <= 1'b0;
        endcase
      end
    end
  end

  assign spi_miso      = miso_q & ~spi_cs_n;
  assign reg_addr      = addr_q;
  assign reg_data_o    = wdata_q;
  assign reg_data_o_dv = dv_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: directed frames push expected strobes/read bytes,
// monitors pop and compare whenever the DUT strobes or a read byte has been collected.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [3:0] reg_addr;
  logic [7:0] reg_data_i;
  logic [7:0] reg_data_o;
  logic       reg_data_o_dv;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] rd_got_q[$];

  spi_reg_bridge #(.ADDR_W(4)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .ena          (ena),
    .spi_cs_n     (spi_cs_n),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .reg_addr     (reg_addr),
    .reg_data_i   (reg_data_i),
    .reg_data_o   (reg_data_o),
    .reg_data_o_dv(reg_data_o_dv)
  );

  always #5 clk = ~clk;

  // peripheral model: data at address a is {a, ~a}, e.g. addr 3 -> 0x3C
  assign reg_data_i = {reg_addr, ~reg_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reg_data_o_dv === 1'b1) begin
      chk("strobe_expected", (wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        wr_t e;
        e = wr_q.pop_front();
        chk("strobe_addr", reg_addr, e.a);
        chk("strobe_data", reg_data_o, e.d);
      end
    end
    if (rd_got_q.size() > 0 && rd_exp_q.size() > 0) begin
      logic [7:0] g, x;
      g = rd_got_q.pop_front();
      x = rd_exp_q.pop_front();
      chk("read_byte", g, x);
    end
  end

  // word is left-aligned; rst_at >= 0 pulses rstb before that bit
  task automatic xfer(input logic [31:0] word, input int nbits, input bit is_read, input int rst_at);
    logic [23:0] rdw;
    logic        hi;
    rdw = '0;
    hi  = 1'b0;
    spi_cs_n = 1'b0;
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rstb = 1'b0;
        tick(2);
        chk("rst_addr", reg_addr, 0);
        chk("rst_data", reg_data_o, 0);
        chk("rst_dv", reg_data_o_dv, 0);
        chk("rst_miso", spi_miso, 0);
        rstb = 1'b1;
        tick(2);
      end
      spi_mosi = word[31-i];
      tick(5);
      if (i >= 8 && i < 32) rdw[31-i] = spi_miso;
      if (!is_read || i < 8) hi = hi | spi_miso;
      spi_clk = 1'b1;
      tick(5);
      spi_clk = 1'b0;
    end
    tick(5);
    spi_cs_n = 1'b1;
    tick(2);
    chk("miso_cs_high", spi_miso, 0);
    tick(8);
    chk("miso_quiet", hi, 0);
    if (is_read)
      for (int b = 0; b < (nbits - 8) / 8; b++)
        rd_got_q.push_back(rdw[23-8*b -: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0;
    tick(3);
    chk("reset_addr", reg_addr, 0);
    chk("reset_data", reg_data_o, 0);
    chk("reset_dv", reg_data_o_dv, 0);
    chk("reset_miso", spi_miso, 0);
    rstb = 1'b1;
    tick(3);

    wr_q.push_back('{a: 4'h5, d: 8'hA5});
    xfer(32'h85A5_0000, 16, 1'b0, -1);
    chk("t1_addr", reg_addr, 4'h5);
    chk("t1_data", reg_data_o, 8'hA5);

    rd_exp_q.push_back(8'h3C);
    xfer(32'h0300_0000, 16, 1'b1, -1);
    chk("t2_addr", reg_addr, 4'h3);
    chk("t2_data_hold", reg_data_o, 8'hA5);

    xfer(32'h8277_0000, 12, 1'b0, -1);
    chk("t3_abort_addr", reg_addr, 4'h2);
    chk("t3_abort_data", reg_data_o, 8'hA5);
    wr_q.push_back('{a: 4'h2, d: 8'h11});
    xfer(32'h8211_0000, 16, 1'b0, -1);
    chk("t3_data", reg_data_o, 8'h11);

    ena = 1'b0;
    xfer(32'h8FFF_0000, 16, 1'b0, -1);
    ena = 1'b1;
    chk("t4_addr", reg_addr, 4'h2);
    chk("t4_data", reg_data_o, 8'h11);

    xfer(32'h8777_0000, 16, 1'b0, 10);
    chk("t5_post_reset_addr", reg_addr, 4'h0);
    chk("t5_post_reset_data", reg_data_o, 8'h00);
    wr_q.push_back('{a: 4'h1, d: 8'h42});
    xfer(32'h8142_0000, 16, 1'b0, -1);
    chk("t5_addr", reg_addr, 4'h1);
    chk("t5_data", reg_data_o, 8'h42);

    wr_q.push_back('{a: 4'hF, d: 8'h01});
`ifdef SPI_REG_BRIDGE_BURST_EN
    wr_q.push_back('{a: 4'h0, d: 8'h02});
    wr_q.push_back('{a: 4'h1, d: 8'h03});
`endif
    xfer(32'h8F01_0203, 32, 1'b0, -1);
`ifdef SPI_REG_BRIDGE_BURST_EN
    chk("t6_final_addr", reg_addr, 4'h2);
    chk("t6_final_data", reg_data_o, 8'h03);
`else
    chk("t6_final_addr", reg_addr, 4'hF);
    chk("t6_final_data", reg_data_o, 8'h01);
`endif

    rd_exp_q.push_back(8'hE1);
`ifdef SPI_REG_BRIDGE_BURST_EN
    rd_exp_q.push_back(8'hF0);
`else
    rd_exp_q.push_back(8'h00);
`endif
    xfer(32'h0E00_0000, 24, 1'b1, -1);

    tick(10);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_exp_drained", rd_exp_q.size(), 0);
    chk("rd_got_drained", rd_got_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
